// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: load-use bubble, redirect flush, memory-wait freeze.
// Optional build macro HAZARD_PERF_EN enables the stall/flush performance counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [2:0] FC_FULL    = 3'(FLUSH_CYCLES);
    localparam logic [2:0] FC_REST    = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] left_q, left_d;
    logic       lu_hazard;
    logic       redirect_act;

    assign state     = state_q;
    assign lu_hazard = ex_memread && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // left_q != 0 means a redirect flush is in progress or pending; it survives MEM_WAIT untouched.
    assign redirect_act = !mem_busy && ((left_q != 3'd0) || ex_redirect);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            left_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
        end
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        if (mem_busy) begin
            state_d = S_MEM_WAIT;
            // A redirect seen during the freeze is held as a full flush to run on release.
            if ((left_q == 3'd0) && ex_redirect)
                left_d = FC_FULL;
        end else if (left_q != 3'd0) begin
            left_d  = left_q - 3'd1;
            state_d = (left_q == 3'd1) ? S_RUN : S_REDIRECT;
        end else if (ex_redirect) begin
            left_d  = FC_REST;
            state_d = (FLUSH_CYCLES > 1) ? S_REDIRECT : S_RUN;
        end else begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (redirect_act) begin
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             redirect_event;

    // Each redirect is counted once, when it is first accepted (live or latched under mem_busy).
    assign redirect_event = ex_redirect && (left_q == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write)
                stall_q <= stall_q + CNT_W'(1);
            if (redirect_event)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS datapath.
- Generates the PC write enable, the IF/ID write and flush controls, and the ID/EX control-flush (drives ctrflush of the ID/EX register).
- Inserts the load-use bubble, flushes wrong-path instructions on taken branch/jump resolved in EX, and freezes the pipeline during multi-cycle data-memory waits.

Parameters:
FLUSH_CYCLES, 1, number of cycles IF/ID and ID/EX are flushed per redirect; legal range 1..4.
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source (R-type, beq, sw)
ex_memread  input  1  instruction in EX is a load
ex_rt  input  5  destination rt of the instruction in EX
ex_redirect  input  1  taken branch or jump resolved in EX this cycle
mem_busy  input  1  data memory not ready; the MEM stage must hold
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register load enable
ifid_flush  output  1  IF/ID register clear to NOP
idex_flush  output  1  ID/EX control clear (bubble)
pipe_hold  output  1  global hold for ID/EX, EX/MEM and MEM/WB
state  output  2  current FSM state: 0 RUN, 1 REDIRECT, 2 MEM_WAIT
stall_cnt  output  CNT_W  cycles with pc_write=0 and the ctrl not in reset
flush_cnt  output  CNT_W  redirect events counted

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0. While reset is held, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
- Outputs are Mealy (combinational from state and inputs); the state and counters are registered on the clk rising edge.
- lu_hazard = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority, highest first: mem_busy, then ex_redirect / REDIRECT state, then lu_hazard, then normal.
- mem_busy=1, any state: pipe_hold=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0. Next state is MEM_WAIT. If a redirect arrives in the same cycle, it is latched as pending. The REDIRECT countdown is paused and not lost.
- MEM_WAIT with mem_busy=0:
  - Resume to REDIRECT if a redirect is pending or the flush count is nonzero; otherwise resume to RUN.
  - Outputs in the resume cycle are evaluated as in the target state.
- RUN with ex_redirect=1 (mem_busy=0):
  - pc_write=1 (the target is loaded), ifid_flush=1, idex_flush=1, ifid_write=0.
  - flush_cnt increments by 1.
  - If FLUSH_CYCLES>1: go to REDIRECT with the remaining count = FLUSH_CYCLES-1. Otherwise stay in RUN.
- REDIRECT: ifid_flush=1, idex_flush=1, pc_write=1. The count decrements each cycle and the block returns to RUN when it reaches 0. ex_redirect inputs are ignored while in REDIRECT, because EX holds bubbles.
- RUN with lu_hazard=1 and no redirect: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1. This is exactly one bubble; the next cycle EX holds the bubble, so lu_hazard clears naturally.
- RUN with no condition active: pc_write=1, ifid_write=1, all flushes and pipe_hold=0.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-REDIRECT or mid-MEM_WAIT: the pending redirect is discarded and the state returns to RUN immediately.

Optional Feature:
HAZARD_PERF_EN:
- Defined: stall_cnt and flush_cnt are live as specified above.
- Undefined: the counter registers are not instantiated, and stall_cnt and flush_cnt are tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- lw $2 in EX (ex_memread=1, ex_rt=2), id_rs=2 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; the next cycle is back to normal; stall_cnt=1.
- Same as above but ex_rt=0, or id_rt=2 with id_uses_rt=0 -> no stall; pc_write=1, idex_flush=0.
- FLUSH_CYCLES=3, ex_redirect pulse -> ifid_flush=idex_flush=1 for 3 consecutive cycles, state goes RUN->REDIRECT->REDIRECT->RUN, flush_cnt=1.
- mem_busy held 4 cycles, with ex_redirect=1 and lu_hazard=1 in the first of those cycles -> 4 cycles of pipe_hold=1 with pc_write=0; then the redirect flush executes once after release; flush_cnt=1.
- rst_n driven low mid-REDIRECT (asynchronously, between clock edges) -> state=0 and flushes asserted immediately; after release, first cycle pc_write=1 with no residual flush.
- Build without HAZARD_PERF_EN, run the load-use and redirect scenarios -> stall_cnt=flush_cnt=0 throughout, with control outputs identical to the build with the macro defined.
